// File: rtl/bsc_scan_master.sv
// bsc_scan_master: on-chip scan driver for the virtual boundary-scan cell
// chain. Runs one Capture-Shift-Update pass per command. It generates tck,
// tdi and the cdr/sdr/udr strobes, and returns the tdo bits seen in Shift.
// Optional feature: define BSC_SCAN_LOOPBACK_EN to add the 'loopback' input.
// When loopback is high, the Shift sample is taken from the registered tdi
// instead of tdo.
module bsc_scan_master #(
  parameter int CHAIN_LEN = 12,
  parameter int LEN_W     = 4,
  parameter int TCK_DIV   = 4
) (
  input  logic                 CLK2,
  input  logic                 RST_N,
`ifdef BSC_SCAN_LOOPBACK_EN
  input  logic                 loopback,
`endif
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic [CHAIN_LEN-1:0] cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_data,
  output logic                 tck,
  output logic                 tdi,
  input  logic                 tdo,
  output logic                 vjtag_cdr,
  output logic                 vjtag_sdr,
  output logic                 vjtag_udr
);

  localparam int CW = $clog2(2 * TCK_DIV) + 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(2 * TCK_DIV - 1);
  localparam logic [CW-1:0]    CNT_HIGH = CW'(TCK_DIV);
  localparam logic [CW-1:0]    CNT_RISE = CW'(TCK_DIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(CHAIN_LEN);

  typedef enum logic [2:0] {IDLE, CAP, SHIFT, UPD, RSP} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [LEN_W-1:0]     idx_q, idx_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [CHAIN_LEN-1:0] sr_q;
  logic [CHAIN_LEN-1:0] rsp_q;
  logic                 tck_q, tck_d;
  logic                 tdi_q, tdi_d;
  logic                 cdr_q, sdr_q, udr_q;
  logic                 accept, period_end, scanning_d, shift_en, sample_en;
  logic                 sample;

`ifdef BSC_SCAN_LOOPBACK_EN
  logic lb_q;

  // Loopback mode is captured at accept and stays fixed for the whole command.
  always_ff @(posedge CLK2 or negedge RST_N) begin
    if (!RST_N)      lb_q <= 1'b0;
    else if (accept) lb_q <= loopback;
  end

  assign sample = lb_q ? tdi_q : tdo;
`else
  assign sample = tdo;
`endif

  // Next-state logic: sequencer, tck period counter, shift index and registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    len_d      = len_q;
    accept     = 1'b0;
    period_end = (cnt_q == CNT_LAST);
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = CAP;
          cnt_d   = '0;
          idx_d   = '0;
          len_d   = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
        end
      end
      CAP: begin
        cnt_d = cnt_q + 1'b1;
        if (period_end) begin
          cnt_d   = '0;
          state_d = (len_q != '0) ? SHIFT : UPD;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (period_end) begin
          cnt_d = '0;
          idx_d = idx_q + 1'b1;
          if (idx_q == len_q - 1'b1) state_d = UPD;
        end
      end
      UPD: begin
        cnt_d = cnt_q + 1'b1;
        if (period_end) begin
          cnt_d   = '0;
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are derived from the next state so that they leave the register
    // clean. They change only at the first cycle of a low phase, except tck.
    scanning_d = (state_d == CAP) || (state_d == SHIFT) || (state_d == UPD);
    tck_d      = scanning_d && (cnt_d >= CNT_HIGH);
    shift_en   = (state_d == SHIFT) && (cnt_d == '0);
    tdi_d      = (state_d != SHIFT) ? 1'b0 : (shift_en ? sr_q[0] : tdi_q);
    // Sample tdo on the CLK2 edge that raises tck. This happens before the
    // chain shifts on that same rise.
    sample_en  = (state_q == SHIFT) && (cnt_q == CNT_RISE);
  end

  // Control and output registers; a reset aborts any scan in progress.
  always_ff @(posedge CLK2 or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      tck_q   <= 1'b0;
      tdi_q   <= 1'b0;
      cdr_q   <= 1'b0;
      sdr_q   <= 1'b0;
      udr_q   <= 1'b0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      tck_q   <= tck_d;
      tdi_q   <= tdi_d;
      cdr_q   <= (state_d == CAP);
      sdr_q   <= (state_d == SHIFT);
      udr_q   <= (state_d == UPD);
      if (accept)         rsp_q        <= '0;
      else if (sample_en) rsp_q[idx_q] <= sample;
    end
  end

  // Shift-in data register; no reset is needed because it is loaded on every accept.
  always_ff @(posedge CLK2) begin
    if (accept)        sr_q <= cmd_data;
    else if (shift_en) sr_q <= sr_q >> 1;
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RSP);
  assign rsp_data  = rsp_q;
  assign tck       = tck_q;
  assign tdi       = tdi_q;
  assign vjtag_cdr = cdr_q;
  assign vjtag_sdr = sdr_q;
  assign vjtag_udr = udr_q;

endmodule
